// File: rtl/score_digits_display_pkg.sv
// Shared glyph geometry, FSM state type and seven-segment encoding for the score banner.
package score_digits_display_pkg;

    localparam int CellW  = 12;
    localparam int CellH  = 28;
    localparam int Stroke = 4;

    localparam int XRight = CellW - Stroke;
    localparam int YMid0  = (CellH - Stroke) / 2;
    localparam int YMid1  = YMid0 + Stroke;
    localparam int YBot   = CellH - Stroke;

    typedef enum logic [1:0] {
        StIdle,
        StConvert,
        StCommit
    } conv_state_e;

    // Half-open rectangle relative to the cell origin.
    typedef struct packed {
        logic [4:0] x0;
        logic [4:0] x1;
        logic [4:0] y0;
        logic [4:0] y1;
    } seg_rect_t;

    // Index 0..6 = segments a..g.
    localparam seg_rect_t SegRect [7] = '{
        '{5'd0,          5'(CellW), 5'd0,         5'(Stroke)},
        '{5'(XRight),    5'(CellW), 5'd0,         5'(YMid1)},
        '{5'(XRight),    5'(CellW), 5'(YMid0),    5'(CellH)},
        '{5'd0,          5'(CellW), 5'(YBot),     5'(CellH)},
        '{5'd0,          5'(Stroke), 5'(YMid0),   5'(CellH)},
        '{5'd0,          5'(Stroke), 5'd0,        5'(YMid1)},
        '{5'd0,          5'(CellW), 5'(YMid0),    5'(YMid1)}
    };

    // Bit s lights segment s (bit 0 = a).
    localparam logic [6:0] SegEnc [10] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    function automatic logic seg_hit(input logic [3:0] digit, input int dx, input int dy);
        logic [6:0] segs;
        logic       hit;
        segs = (digit < 4'd10) ? SegEnc[digit] : 7'h00;
        hit  = 1'b0;
        for (int s = 0; s < 7; s++) begin
            if (segs[s] && dx >= int'(SegRect[s].x0) && dx < int'(SegRect[s].x1) &&
                dy >= int'(SegRect[s].y0) && dy < int'(SegRect[s].y1)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/score_digits_display_if.sv
// Pixel-position, score and status signals between the video timing side and the renderer.
interface score_digits_display_if #(
    parameter int SCORE_BITS = 10
) ();
    logic [9:0]            i_vpos;
    logic [9:0]            i_hpos;
    logic [SCORE_BITS-1:0] i_score;
    logic                  i_frame_start;
    logic [2:0]            o_score_rgb;
    logic                  o_busy;
    logic                  o_overflow;

    modport master (
        output i_vpos, i_hpos, i_score, i_frame_start,
        input  o_score_rgb, o_busy, o_overflow
    );

    modport slave (
        input  i_vpos, i_hpos, i_score, i_frame_start,
        output o_score_rgb, o_busy, o_overflow
    );
endinterface

// File: rtl/score_digits_display_bin2bcd_seq.sv
// Iterative double-dabble: one add-3/shift step per cycle, then a one-cycle done in StCommit.
module bin2bcd_seq
    import score_digits_display_pkg::*;
#(
    parameter int SCORE_BITS = 10
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic                                start_i,
    input  logic [SCORE_BITS-1:0]               bin_i,
    output logic                                busy_o,
    output logic                                done_o,
    output logic [4*((SCORE_BITS+2)/3)-1:0]     bcd_o
);
    localparam int BcdNib = (SCORE_BITS + 2) / 3;
    localparam int BcdW   = 4 * BcdNib;
    localparam int CntW   = $clog2(SCORE_BITS + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(SCORE_BITS - 1);

    conv_state_e           state_q;
    logic [SCORE_BITS-1:0] bin_q, bin_d;
    logic [BcdW-1:0]       bcd_q, bcd_d;
    logic [CntW-1:0]       cnt_q;
    logic [BcdW-1:0]       adj;

    always_comb begin
        adj = bcd_q;
        for (int n = 0; n < BcdNib; n++) begin
            if (adj[4*n +: 4] >= 4'd5) adj[4*n +: 4] = adj[4*n +: 4] + 4'd3;
        end
        {bcd_d, bin_d} = {adj, bin_q} << 1;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        bin_q   <= bin_i;
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= StConvert;
                    end
                end
                StConvert: begin
                    bin_q <= bin_d;
                    bcd_q <= bcd_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LastCnt) state_q <= StCommit;
                end
                StCommit: state_q <= StIdle;
                default:  state_q <= StIdle;
            endcase
        end
    end

    assign busy_o = (state_q != StIdle);
    assign done_o = (state_q == StCommit);
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/score_digits_display.sv
// Score banner: per-frame BCD conversion, atomic commit with overflow clamp, registered pixel.
module score_digits_display
    import score_digits_display_pkg::*;
#(
    parameter int         SCORE_BITS   = 10,
    parameter int         NUM_DIGITS   = 4,
    parameter int         X0           = 576,
    parameter int         Y0           = 2,
    parameter int         DIGIT_GAP    = 4,
    parameter int         BANNER_H     = 32,
    parameter bit         LZ_BLANK     = 1'b1,
    parameter logic [2:0] DIGIT_COLOR  = 3'b100,
    parameter logic [2:0] BANNER_COLOR = 3'b000
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    score_digits_display_if.slave  bus
);
    localparam int BcdNib = (SCORE_BITS + 2) / 3;
    localparam int MaxNib = (BcdNib > NUM_DIGITS) ? BcdNib : NUM_DIGITS;

    logic [4*BcdNib-1:0]     bcd;
    logic                    done;
    logic [4*MaxNib-1:0]     bcd_pad;
    logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
    logic                    ovf_q, ovf_d;
    logic [2:0]              rgb_q, rgb_d;

    bin2bcd_seq #(
        .SCORE_BITS (SCORE_BITS)
    ) u_bin2bcd (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .start_i (bus.i_frame_start),
        .bin_i   (bus.i_score),
        .busy_o  (bus.o_busy),
        .done_o  (done),
        .bcd_o   (bcd)
    );

    // Nibbles above the displayed digits only feed the overflow flag.
    always_comb begin
        bcd_pad = (4*MaxNib)'(bcd);
        ovf_d   = |(bcd_pad >> (4 * NUM_DIGITS));
        disp_d  = ovf_d ? {NUM_DIGITS{4'd9}} : bcd_pad[4*NUM_DIGITS-1:0];
    end

    always_comb begin : pix_comb
        int         cell_x;
        int         dx;
        int         dy;
        logic       lead_zero;
        logic [3:0] dig;
        cell_x    = 0;
        dx        = 0;
        dy        = 0;
        lead_zero = 1'b1;
        dig       = 4'd0;
        rgb_d     = 3'b000;
        if (int'(bus.i_vpos) < BANNER_H) begin
            rgb_d = BANNER_COLOR;
            dy    = int'(bus.i_vpos) - Y0;
            for (int n = 0; n < NUM_DIGITS; n++) begin
                dig       = disp_q[4*(NUM_DIGITS-1-n) +: 4];
                lead_zero = lead_zero && (dig == 4'd0);
                cell_x    = X0 + n * (CellW + DIGIT_GAP);
                dx        = int'(bus.i_hpos) - cell_x;
                if (!(LZ_BLANK && lead_zero && (n < NUM_DIGITS - 1)) &&
                    dx >= 0 && dx < CellW && dy >= 0 && dy < CellH && seg_hit(dig, dx, dy)) begin
                    rgb_d = DIGIT_COLOR;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            disp_q <= '0;
            ovf_q  <= 1'b0;
            rgb_q  <= 3'b000;
        end else begin
            rgb_q <= rgb_d;
            if (done) begin
                disp_q <= disp_d;
                ovf_q  <= ovf_d;
            end
        end
    end

    assign bus.o_score_rgb = rgb_q;
    assign bus.o_overflow  = ovf_q;

endmodule

// File: tb/tb_score_digits_display.sv
// Scoreboarded bench: three renderer configurations (default, 3 digits, no blanking).
module tb_score_digits_display;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] hpos, vpos, score;
    logic       fs_a, fs_b, fs_c;
    logic       probe_v = 1'b0;
    logic       pend = 1'b0;
    int         n_checks = 0;
    int         n_pass = 0;
    int         len;

    typedef struct {
        int         dut;
        logic [2:0] exp;
        string      name;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    score_digits_display_if #(.SCORE_BITS(10)) if_a ();
    score_digits_display_if #(.SCORE_BITS(10)) if_b ();
    score_digits_display_if #(.SCORE_BITS(10)) if_c ();

    assign if_a.i_hpos = hpos;  assign if_a.i_vpos = vpos;
    assign if_a.i_score = score; assign if_a.i_frame_start = fs_a;
    assign if_b.i_hpos = hpos;  assign if_b.i_vpos = vpos;
    assign if_b.i_score = score; assign if_b.i_frame_start = fs_b;
    assign if_c.i_hpos = hpos;  assign if_c.i_vpos = vpos;
    assign if_c.i_score = score; assign if_c.i_frame_start = fs_c;

    score_digits_display u_a (.i_clk(clk), .i_rst_n(rst_n), .bus(if_a.slave));
    score_digits_display #(.NUM_DIGITS(3)) u_b (.i_clk(clk), .i_rst_n(rst_n), .bus(if_b.slave));
    score_digits_display #(.LZ_BLANK(1'b0)) u_c (.i_clk(clk), .i_rst_n(rst_n), .bus(if_c.slave));

    function automatic logic [2:0] rgb_of(input int d);
        case (d)
            0:       return if_a.o_score_rgb;
            1:       return if_b.o_score_rgb;
            default: return if_c.o_score_rgb;
        endcase
    endfunction

    function automatic logic busy_of(input int d);
        case (d)
            0:       return if_a.o_busy;
            1:       return if_b.o_busy;
            default: return if_c.o_busy;
        endcase
    endfunction

    function automatic logic ovf_of(input int d);
        case (d)
            0:       return if_a.o_overflow;
            1:       return if_b.o_overflow;
            default: return if_c.o_overflow;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fs(input int d, input logic v);
        case (d)
            0:       fs_a = v;
            1:       fs_b = v;
            default: fs_c = v;
        endcase
    endtask

    // The pixel presented at one edge is expected on the output after the next edge.
    task automatic probe(input int d, input int x, input int y, input logic [2:0] exp,
                         input string name);
        hpos = 10'(x);
        vpos = 10'(y);
        sb.push_back('{d, exp, name});
        probe_v = 1'b1;
        tick();
        probe_v = 1'b0;
    endtask

    task automatic frame(input int d, input int sc, input int dup_at, input int dup_sc,
                         output int blen);
        score = 10'(sc);
        set_fs(d, 1'b1);
        tick();
        set_fs(d, 1'b0);
        check($sformatf("busy_rise_dut%0d", d), int'(busy_of(d)), 1);
        blen = 0;
        while (busy_of(d) && blen < 100) begin
            if (blen == dup_at) begin
                score = 10'(dup_sc);
                set_fs(d, 1'b1);
            end else begin
                set_fs(d, 1'b0);
            end
            blen++;
            tick();
        end
        set_fs(d, 1'b0);
    endtask

    always @(posedge clk) pend <= probe_v;

    always @(negedge clk) begin
        if (pend) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL sb_underflow: got output with no expectation queued");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check(e.name, int'(rgb_of(e.dut)), int'(e.exp));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        fs_a = 1'b0; fs_b = 1'b0; fs_c = 1'b0;
        score = '0;
        hpos = 10'd624;
        vpos = 10'd2;
        repeat (3) tick();
        check("reset_rgb", int'(rgb_of(0)), 0);
        check("reset_busy", int'(busy_of(0)), 0);
        check("reset_ovf", int'(ovf_of(0)), 0);
        check("reset_rgb_c", int'(rgb_of(2)), 0);
        rst_n = 1'b1;
        vpos = 10'd500;
        tick();

        frame(0, 0, -1, 0, len);
        check("busy_len_zero", len, 11);
        probe(0, 624, 2, 3'b100, "zero_seg_a");
        probe(0, 630, 16, 3'b000, "zero_hole");
        probe(0, 580, 10, 3'b000, "zero_cell0");
        probe(0, 576, 2, 3'b000, "zero_cell0_blank");

        frame(0, 709, -1, 0, len);
        check("busy_len_709", len, 11);
        probe(0, 576, 2, 3'b000, "709_cell0_blank");
        probe(0, 593, 2, 3'b100, "709_7_seg_a");
        probe(0, 592, 20, 3'b000, "709_7_no_e");
        probe(0, 613, 10, 3'b000, "709_0_hole");
        probe(0, 608, 2, 3'b100, "709_0_seg_a");
        probe(0, 624, 14, 3'b100, "709_9_seg_g");
        probe(0, 624, 20, 3'b000, "709_9_no_e");
        probe(0, 589, 10, 3'b000, "709_gap");

        frame(1, 1023, -1, 0, len);
        check("busy_len_1023", len, 11);
        check("ovf_1023", int'(ovf_of(1)), 1);
        probe(1, 576, 2, 3'b100, "999_msd_a");
        probe(1, 592, 14, 3'b100, "999_mid_g");
        probe(1, 608, 20, 3'b000, "999_lsd_no_e");
        frame(1, 5, -1, 0, len);
        check("ovf_5", int'(ovf_of(1)), 0);
        probe(1, 576, 2, 3'b000, "5_msd_blank");
        probe(1, 608, 2, 3'b100, "5_seg_a");
        probe(1, 619, 8, 3'b000, "5_no_b");
        probe(1, 608, 8, 3'b100, "5_seg_f");

        frame(0, 123, 3, 456, len);
        check("busy_len_ignored", len, 11);
        probe(0, 576, 2, 3'b000, "123_cell0_blank");
        probe(0, 592, 8, 3'b000, "123_1_no_f");
        probe(0, 600, 2, 3'b100, "123_1_seg_b");
        probe(0, 608, 20, 3'b100, "123_2_seg_e");
        probe(0, 624, 20, 3'b000, "123_3_no_e");
        tick();
        check("ignored_not_busy", int'(busy_of(0)), 0);

        frame(2, 42, -1, 0, len);
        check("busy_len_42", len, 11);
        probe(2, 576, 2, 3'b100, "0042_lead_zero_shown");
        probe(2, 580, 16, 3'b000, "0042_hole");
        probe(2, 576, 2, 3'b100, "0042_lag_a");
        probe(2, 612, 2, 3'b000, "0042_4_no_a");
        probe(2, 624, 20, 3'b100, "0042_2_seg_e");
        probe(2, 600, 40, 3'b000, "0042_below_banner");
        probe(2, 576, 40, 3'b000, "0042_below_banner_cell");

        score = 10'd888;
        set_fs(0, 1'b1);
        tick();
        set_fs(0, 1'b0);
        repeat (5) tick();
        hpos = 10'd624;
        vpos = 10'd2;
        rst_n = 1'b0;
        tick();
        check("midreset_rgb", int'(rgb_of(0)), 0);
        check("midreset_busy", int'(busy_of(0)), 0);
        check("midreset_ovf", int'(ovf_of(0)), 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("postreset_busy", int'(busy_of(0)), 0);
        probe(0, 632, 2, 3'b100, "postreset_0_seg_a");
        probe(0, 624, 16, 3'b100, "postreset_0_seg_e");
        probe(0, 630, 16, 3'b000, "postreset_0_hole");
        probe(0, 608, 20, 3'b000, "postreset_cell2_blank");

        vpos = 10'd500;
        repeat (3) tick();
        check("sb_drain", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
